weight_row_loader: RTL and testbench

WEIGHT_ROW_LOADER -- requirements
Module: weight_row_loader

---
 rtl/weight_row_loader_pkg.sv | 18 +
 rtl/weight_row_loader_edge.sv | 24 ++
 rtl/weight_row_loader.sv | 132 +++++++++++++
 tb/tb_weight_row_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_row_loader_pkg.sv
// Shared definitions for the weight fill and row loader stages: the loader
// FSM state encoding and the width rule for row index signals.
package weight_row_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } loader_state_e;

    // Bits needed to index n rows; never narrower than one bit so a 1x1
    // array still has a legal index port.
    function automatic int row_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_row_loader_edge.sv
// Registered rising-edge detector. The registered copy clears on reset, so a
// level that is already high when reset lifts reads as a rising edge on the
// first clock.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Keep last cycle's level to compare against the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/weight_row_loader.sv
// Weight row loader: on a fill_done rising edge, captures the full weight
// matrix, streams the requested number of rows (row 0 first) toward the
// systolic array, pulses weight_load once, then holds the weights as resident
// until the compute controller releases them.
// "release" is a reserved word, so the controller's release pulse arrives on
// release_req.
module weight_row_loader
    import weight_row_loader_pkg::*;
#(
    parameter int data_size     = 16,
    parameter int array_size    = 9,
    parameter int dim_data_size = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      fill_done,
    input  logic [data_size*array_size*array_size-1:0] weight_in,
    input  logic [dim_data_size-1:0]                  weight_rows,
    input  logic                                      release_req,
    output logic [data_size*array_size-1:0]           row_data,
    output logic                                      row_valid,
    output logic [row_idx_w(array_size)-1:0]          row_index,
    output logic                                      weight_load,
    output logic                                      ready,
    output logic                                      busy,
    output logic                                      overrun
);

    localparam int ROW_W = data_size * array_size;
    localparam int MAT_W = ROW_W * array_size;
    localparam int IDX_W = row_idx_w(array_size);
    localparam int CNT_W = $clog2(array_size + 1);

    loader_state_e    state;
    logic [MAT_W-1:0] weight_buf;
    logic [MAT_W-1:0] buf_shifted;
    logic [CNT_W-1:0] rows_left;
    logic             fill_rise;

    // A zero or oversized request means "load the whole array".
    function automatic logic [CNT_W-1:0] clamp_rows(input logic [dim_data_size-1:0] req);
        if (req == '0 || req > dim_data_size'(array_size)) begin
            return CNT_W'(array_size);
        end
        return req[CNT_W-1:0];
    endfunction

    edge_detect_rise u_fill_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (fill_done),
        .rise  (fill_rise)
    );

    // Buffer as it will look once the row currently on row_data is consumed.
    always_comb begin
        buf_shifted = weight_buf << ROW_W;
    end

    // Loader FSM with registered outputs. The buffer's top slice is always
    // the row being presented; rows_left counts rows still to present,
    // including the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            weight_buf  <= '0;
            rows_left   <= '0;
            row_data    <= '0;
            row_valid   <= 1'b0;
            row_index   <= '0;
            weight_load <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // A new matrix arriving while the previous one is still in use
            // is lost; remember that it happened.
            if (fill_rise && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fill_rise) begin
                        weight_buf <= weight_in;
                        rows_left  <= clamp_rows(weight_rows);
                        row_data   <= weight_in[MAT_W-1 -: ROW_W];
                        row_valid  <= 1'b1;
                        row_index  <= '0;
                        busy       <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (rows_left == CNT_W'(1)) begin
                        row_data    <= '0;
                        row_valid   <= 1'b0;
                        row_index   <= '0;
                        rows_left   <= '0;
                        weight_load <= 1'b1;
                        state       <= ST_COMMIT;
                    end else begin
                        weight_buf <= buf_shifted;
                        row_data   <= buf_shifted[MAT_W-1 -: ROW_W];
                        row_index  <= row_index + IDX_W'(1);
                        rows_left  <= rows_left - CNT_W'(1);
                    end
                end

                ST_COMMIT: begin
                    weight_load <= 1'b0;
                    busy        <= 1'b0;
                    ready       <= 1'b1;
                    state       <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (release_req) begin
                        ready <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_row_loader.sv
// Scoreboard bench for weight_row_loader with a 3x3 array of 16-bit words.
module tb_weight_row_loader;

    localparam int DW    = 16;
    localparam int AS    = 3;
    localparam int DD    = 16;
    localparam int ROW_W = DW * AS;
    localparam int MAT_W = ROW_W * AS;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fill_done = 1'b0;
    logic             release_req = 1'b0;
    logic [MAT_W-1:0] weight_in = '0;
    logic [DD-1:0]    weight_rows = '0;
    logic [ROW_W-1:0] row_data;
    logic             row_valid;
    logic [1:0]       row_index;
    logic             weight_load;
    logic             ready;
    logic             busy;
    logic             overrun;

    typedef struct {
        bit               is_load;
        int               cyc;
        logic [ROW_W-1:0] data;
        int               idx;
    } exp_t;

    exp_t q[$];
    int   edges = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   model_overrun = 1'b0;
    int   bs_lo = 1, bs_hi = 0;
    int   rdy_lo = 1, rdy_hi = 0;

    weight_row_loader #(
        .data_size     (DW),
        .array_size    (AS),
        .dim_data_size (DD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fill_done   (fill_done),
        .weight_in   (weight_in),
        .weight_rows (weight_rows),
        .release_req (release_req),
        .row_data    (row_data),
        .row_valid   (row_valid),
        .row_index   (row_index),
        .weight_load (weight_load),
        .ready       (ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, edges, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int info);
        vectors++;
        miscompares++;
        $display("FAIL %s at cycle %0d: got event/absence at %0d, required the opposite", name, edges, info);
    endtask

    // Monitor: compares every presented row / load strobe against the
    // scoreboard, and checks busy/ready/overrun against the model's intervals.
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (reset) begin
            if (row_valid) begin
                if (q.size() == 0 || q[0].is_load) begin
                    fail_now("unexpected_row", edges);
                end else begin
                    e = q.pop_front();
                    check("row_cycle", 64'(edges), 64'(e.cyc));
                    check("row_index", 64'(row_index), 64'(e.idx));
                    check("row_data", 64'(row_data), 64'(e.data));
                end
            end else begin
                check("row_data_idle", 64'(row_data), 64'd0);
            end
            if (weight_load) begin
                if (q.size() == 0 || !q[0].is_load) begin
                    fail_now("unexpected_load", edges);
                end else begin
                    e = q.pop_front();
                    check("load_cycle", 64'(edges), 64'(e.cyc));
                end
            end
            while (q.size() > 0 && q[0].cyc < edges) begin
                fail_now("missing_output", q[0].cyc);
                q.delete(0);
            end
            check("busy", 64'(busy), 64'(edges >= bs_lo && edges <= bs_hi));
            check("ready", 64'(ready), 64'(edges >= rdy_lo && edges <= rdy_hi));
            check("overrun", 64'(overrun), 64'(model_overrun));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_row_data"}, 64'(row_data), 64'd0);
        check({tag, "_row_valid"}, 64'(row_valid), 64'd0);
        check({tag, "_row_index"}, 64'(row_index), 64'd0);
        check({tag, "_weight_load"}, 64'(weight_load), 64'd0);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    // Issue one matrix. Rows r of the clamped count appear at cap+1+r, the
    // load strobe at cap+1+n, and ready from cap+2+n until released.
    task automatic do_load(input int rows, input bit pattern, input bit glitch,
                           input bit early_rel, input bit abort);
        int               cap, n;
        logic [ROW_W-1:0] rowv;
        logic [DW-1:0]    w[AS][AS];
        @(negedge clk);
        cap = edges;
        n = (rows == 0 || rows > AS) ? AS : rows;
        weight_in = '0;
        for (int r = 0; r < AS; r++) begin
            for (int c = 0; c < AS; c++) begin
                w[r][c] = pattern ? DW'(16 * r + c) : DW'($urandom);
                weight_in = {weight_in[MAT_W-DW-1:0], w[r][c]};
            end
        end
        weight_rows = DD'(rows);
        fill_done = 1'b1;
        reset = 1'b1;
        for (int r = 0; r < n; r++) begin
            rowv = '0;
            for (int c = 0; c < AS; c++) rowv = {rowv[ROW_W-DW-1:0], w[r][c]};
            q.push_back('{1'b0, cap + 1 + r, rowv, r});
        end
        q.push_back('{1'b1, cap + 1 + n, '0, 0});
        bs_lo = cap + 1;
        bs_hi = cap + 1 + n;
        rdy_lo = cap + 2 + n;
        rdy_hi = 1 << 30;
        while (edges < cap + 2 + n) begin
            @(negedge clk);
            if (edges == cap + 1) begin
                weight_in = MAT_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
                weight_rows = DD'($urandom);
                if (glitch) fill_done = 1'b0;
                if (early_rel) release_req = 1'b1;
            end
            if (edges == cap + 2) begin
                if (glitch) fill_done = 1'b1;
                release_req = 1'b0;
                if (abort) begin
                    #3;
                    reset = 1'b0;
                    fill_done = 1'b0;
                    q.delete();
                    bs_hi = -1;
                    rdy_hi = -1;
                    model_overrun = 1'b0;
                    #1;
                    check_all_zero("abort");
                    return;
                end
            end
            if (edges == cap + 3 && glitch) model_overrun = 1'b1;
        end
        fill_done = 1'b0;
    endtask

    task automatic do_release(input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rdy_hi = edges;
        release_req = 1'b1;
        @(negedge clk);
        release_req = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Known pattern, full matrix.
        do_load(3, 1'b1, 1'b0, 1'b0, 1'b0);
        do_release(0);
        // Clamping of zero and oversized row counts.
        do_load(0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_release(1);
        do_load(7, 1'b0, 1'b0, 1'b0, 1'b0);
        do_release(0);
        // Partial load.
        do_load(2, 1'b1, 1'b0, 1'b0, 1'b0);
        do_release(2);
        // Second fill edge while shifting.
        do_load(3, 1'b0, 1'b1, 1'b0, 1'b0);
        do_release(0);
        // Release while busy is ignored.
        do_load(3, 1'b0, 1'b0, 1'b1, 1'b0);
        do_release(2);
        for (int i = 0; i < 6; i++) begin
            do_load(int'($urandom_range(0, 5)), 1'b0, 1'b0, 1'b0, 1'b0);
            do_release(int'($urandom_range(0, 2)));
        end
        // Reset after the second row, with fill_done high as reset lifts.
        do_load(3, 1'b0, 1'b0, 1'b0, 1'b1);
        fill_done = 1'b1;
        do_load(2, 1'b1, 1'b0, 1'b0, 1'b0);
        do_release(0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
